// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } dmem_state_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side and data-memory-side signals of the MEM-stage access controller.
interface dmem_access_ctrl_if;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] load_data;
  logic        load_valid;
  logic        misalign_fault;
  logic        bus_fault;

  modport slave (
    input  mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
    input  dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output load_data, load_valid, misalign_fault, bus_fault
  );

  modport master (
    output mem_enable, mem_rw, mem_size, mem_se, mem_addr, mem_wdata,
    output dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  load_data, load_valid, misalign_fault, bus_fault
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Big-endian lane steering: store byte enables / replicated data and load extraction / extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        se_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (addr_lo_i)
      2'b00:   rbyte = rdata_i[31:24];
      2'b01:   rbyte = rdata_i[23:16];
      2'b10:   rbyte = rdata_i[15:8];
      default: rbyte = rdata_i[7:0];
    endcase
    rhalf = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

    be_o    = 4'b1111;
    wdata_o = wdata_i;
    load_o  = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b1000 >> addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        load_o  = {{24{se_i & rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b0011 : 4'b1100;
        wdata_o = {2{wdata_i[15:0]}};
        load_o  = {{16{se_i & rhalf[15]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// ============================================================================
// Module      : dmem_access_ctrl
// Description : MEM-stage data-memory sequencer; stalls the pipeline across a
//               req/ack access, aligns lanes, flags misaligned accesses.
//               Optional WAIT timeout with bus_fault (DMEM_CTRL_TIMEOUT_EN).
// Revision    : 1.1
// ============================================================================
`default_nettype none
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
(
    input wire logic          clk,
    input wire logic          reset,
    dmem_access_ctrl_if.slave bus
);

    dmem_state_t r_state, w_state_nxt;
    logic        r_we, r_se;
    logic [29:0] r_addr;
    logic [1:0]  r_size, r_lo;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data, w_load_data_nxt;
    logic        r_lv, w_lv_nxt, r_mf, w_mf_nxt, r_bf, w_bf_nxt;
    logic        w_latch_en, w_timeout, w_sel_idle;
    logic [3:0]  w_be_calc;
    logic [31:0] w_wdata_calc, w_load_ext;

    assign w_sel_idle = (r_state == ST_IDLE);

    dmem_lane_align u_align (
        .size_i    (w_sel_idle ? bus.mem_size      : r_size),
        .se_i      (w_sel_idle ? bus.mem_se        : r_se),
        .addr_lo_i (w_sel_idle ? bus.mem_addr[1:0] : r_lo),
        .wdata_i   (bus.mem_wdata),
        .rdata_i   (bus.dmem_rdata),
        .be_o      (w_be_calc),
        .wdata_o   (w_wdata_calc),
        .load_o    (w_load_ext)
    );

`ifdef DMEM_CTRL_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  r_cnt <= '0;
        else if (r_state == ST_WAIT) r_cnt <= r_cnt + 1'b1;
        else                         r_cnt <= '0;
    end

    assign w_timeout = (r_state == ST_WAIT) && (r_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_latch_en      = 1'b0;
        w_lv_nxt        = 1'b0;
        w_mf_nxt        = 1'b0;
        w_bf_nxt        = 1'b0;
        w_load_data_nxt = r_load_data;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_enable) begin
                    if (is_misaligned(bus.mem_size, bus.mem_addr[1:0])) begin
                        w_state_nxt = ST_DONE;
                        w_mf_nxt    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_latch_en  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ack) begin
                    w_state_nxt = ST_DONE;
                    if (!r_we) begin
                        w_lv_nxt        = 1'b1;
                        w_load_data_nxt = w_load_ext;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_bf_nxt    = 1'b1;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_se        <= 1'b0;
            r_addr      <= '0;
            r_size      <= '0;
            r_lo        <= '0;
            r_be        <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
            r_lv        <= 1'b0;
            r_mf        <= 1'b0;
            r_bf        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_data <= w_load_data_nxt;
            r_lv        <= w_lv_nxt;
            r_mf        <= w_mf_nxt;
            r_bf        <= w_bf_nxt;
            if (w_latch_en) begin
                r_we    <= bus.mem_rw;
                r_se    <= bus.mem_se;
                r_addr  <= bus.mem_addr[31:2];
                r_size  <= bus.mem_size;
                r_lo    <= bus.mem_addr[1:0];
                r_be    <= w_be_calc;
                r_wdata <= w_wdata_calc;
            end
        end
    end

    assign bus.stall          = reset & ((w_sel_idle & bus.mem_enable) | (r_state == ST_WAIT));
    assign bus.dmem_req       = (r_state == ST_WAIT);
    assign bus.dmem_we        = r_we;
    assign bus.dmem_addr      = {r_addr, 2'b00};
    assign bus.dmem_be        = r_be;
    assign bus.dmem_wdata     = r_wdata;
    assign bus.load_data      = r_load_data;
    assign bus.load_valid     = r_lv;
    assign bus.misalign_fault = r_mf;
    assign bus.bus_fault      = r_bf;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
// ============================================================================
// Module      : tb_dmem_access_ctrl
// Description : Self-checking bench for dmem_access_ctrl against a lane/timing
//               reference model.
// Revision    : 1.1
// ============================================================================
`default_nettype none
module tb_dmem_access_ctrl;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    dmem_access_ctrl_if bus();

    always #5 clk = ~clk;

    dmem_access_ctrl #(.TIMEOUT_CYCLES(4)) u_dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic [31:0] exp_load(logic [1:0] sz, logic se, logic [31:0] a, logic [31:0] rd);
        int lo;
        logic [31:0] v;
        lo = int'(a[1:0]);
        if (sz == SZ_BYTE) begin
            v = (rd >> ((3 - lo) * 8)) & 32'h0000_00FF;
            if (se && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == SZ_HALF) begin
            v = (rd >> ((lo < 2) ? 16 : 0)) & 32'h0000_FFFF;
            if (se && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] exp_be(logic [1:0] sz, logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        if (sz == SZ_BYTE) return 4'(1 << (3 - lo));
        if (sz == SZ_HALF) return (lo < 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(logic [1:0] sz, logic [31:0] wd);
        if (sz == SZ_BYTE) return {24'd0, wd[7:0]} * 32'h0101_0101;
        if (sz == SZ_HALF) return {16'd0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic bit exp_mis(logic [1:0] sz, logic [31:0] a);
        if (sz == SZ_BYTE) return 1'b0;
        if (sz == SZ_HALF) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    // Presents one access at posedge+1 and observes it mid-cycle until DONE.
    task automatic run_access(input logic rw, input logic [1:0] sz, input logic se,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                              input int ack_after, input bit noise,
                              output int n_stall, output int n_req, output int n_lv,
                              output int n_mf, output int n_bf, output logic [31:0] ld,
                              output logic [3:0] be_s, output logic [31:0] wd_s,
                              output logic [31:0] addr_s, output logic we_s, output bit done);
        bit seen_stall;
        n_stall = 0; n_req = 0; n_lv = 0; n_mf = 0; n_bf = 0;
        ld = '0; be_s = '0; wd_s = '0; addr_s = '0; we_s = 1'b0;
        done = 1'b0; seen_stall = 1'b0;
        bus.mem_enable = 1'b1; bus.mem_rw = rw; bus.mem_size = sz; bus.mem_se = se;
        bus.mem_addr = a; bus.mem_wdata = wd; bus.dmem_rdata = rd; bus.dmem_ack = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            #4;
            if (bus.stall) begin n_stall++; seen_stall = 1'b1; end
            if (bus.load_valid) begin n_lv++; ld = bus.load_data; end
            if (bus.misalign_fault) n_mf++;
            if (bus.bus_fault) n_bf++;
            if (bus.dmem_req) begin
                n_req++;
                be_s = bus.dmem_be; wd_s = bus.dmem_wdata; addr_s = bus.dmem_addr; we_s = bus.dmem_we;
                bus.dmem_ack = (n_req - 1 == ack_after);
            end else begin
                bus.dmem_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!bus.stall && seen_stall) done = 1'b1;
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
        end
        bus.mem_enable = 1'b0;
    endtask

    int n_stall, n_req, n_lv, n_mf, n_bf;
    logic [31:0] ld, wd_s, addr_s;
    logic [3:0] be_s;
    logic we_s;
    bit done;

    task automatic test_reset();
        bus.mem_enable = 1'b1; bus.mem_rw = 1'b1; bus.mem_size = SZ_WORD; bus.mem_se = 1'b0;
        bus.mem_addr = 32'h40; bus.mem_wdata = 32'h1234_5678; bus.dmem_rdata = '0; bus.dmem_ack = 1'b1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        checks++;
        if ({bus.stall, bus.dmem_req, bus.dmem_we, bus.load_valid, bus.misalign_fault, bus.bus_fault} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got stall=%b req=%b we=%b lv=%b mf=%b bf=%b exp all 0", bus.stall,
                     bus.dmem_req, bus.dmem_we, bus.load_valid, bus.misalign_fault, bus.bus_fault);
        end
        checks++;
        if ({bus.load_data, bus.dmem_addr, bus.dmem_wdata, bus.dmem_be} !== '0) begin
            failures++;
            $display("FAIL reset_data got ld=%h addr=%h wd=%h be=%b exp 0", bus.load_data, bus.dmem_addr,
                     bus.dmem_wdata, bus.dmem_be);
        end
        @(posedge clk); #1;
        bus.mem_enable = 1'b0; bus.dmem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word_load();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (!done || n_stall != 2 || n_req != 1 || n_lv != 1 || n_mf != 0) begin
            failures++;
            $display("FAIL word_load_timing done=%0d stall=%0d req=%0d lv=%0d mf=%0d exp 1/2/1/1/0",
                     done, n_stall, n_req, n_lv, n_mf);
        end
        checks++;
        if (ld !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL word_load_data got=%h exp=DEADBEEF", ld);
        end
    endtask

    task automatic test_byte_load();
        run_access(1'b0, SZ_BYTE, 1'b1, 32'h103, 32'h0, 32'h0000_00F0, 1, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (!done || n_lv != 1 || ld !== 32'hFFFF_FFF0 || n_stall != 3) begin
            failures++;
            $display("FAIL byte_load_se done=%0d lv=%0d stall=%0d got=%h exp=FFFFFFF0", done, n_lv, n_stall, ld);
        end
        run_access(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h0, 32'h0000_00F0, 0, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (!done || n_lv != 1 || ld !== 32'h0000_00F0) begin
            failures++;
            $display("FAIL byte_load_ze done=%0d lv=%0d got=%h exp=000000F0", done, n_lv, ld);
        end
    endtask

    task automatic test_half_store();
        run_access(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0000_ABCD, 32'h5555_5555, 0, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (we_s !== 1'b1 || be_s !== 4'b0011 || wd_s !== 32'hABCD_ABCD || addr_s !== 32'h100) begin
            failures++;
            $display("FAIL half_store_bus we=%b be=%b wd=%h addr=%h exp 1/0011/ABCDABCD/00000100",
                     we_s, be_s, wd_s, addr_s);
        end
        checks++;
        if (!done || n_lv != 0 || n_stall != 2) begin
            failures++;
            $display("FAIL half_store_lv done=%0d lv=%0d stall=%0d exp 1/0/2", done, n_lv, n_stall);
        end
    endtask

    task automatic test_misalign();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h101, 32'h0, 32'h1111_2222, 0, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (!done || n_mf != 1 || n_req != 0 || n_stall != 1 || n_lv != 0) begin
            failures++;
            $display("FAIL misalign done=%0d mf=%0d req=%0d stall=%0d lv=%0d exp 1/1/0/1/0",
                     done, n_mf, n_req, n_stall, n_lv);
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 60; i++) begin
            logic rw, se;
            logic [1:0] sz;
            logic [31:0] a, wd, rd;
            int dly, es, er, el, em;
            bit mis;
            rw = 1'($urandom_range(0, 1)); se = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
            a = $urandom; wd = $urandom; rd = $urandom; dly = $urandom_range(0, 3);
            mis = exp_mis(sz, a);
            es = mis ? 1 : 2 + dly;
            er = mis ? 0 : 1 + dly;
            el = (!mis && !rw) ? 1 : 0;
            em = mis ? 1 : 0;
            run_access(rw, sz, se, a, wd, rd, dly, 1'b1,
                       n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
            checks++;
            if (!done || n_stall != es || n_req != er || n_lv != el || n_mf != em || n_bf != 0) begin
                failures++;
                $display("FAIL rand_timing i=%0d done=%0d stall=%0d/%0d req=%0d/%0d lv=%0d/%0d mf=%0d/%0d bf=%0d",
                         i, done, n_stall, es, n_req, er, n_lv, el, n_mf, em, n_bf);
            end
            if (!mis) begin
                checks++;
                if (be_s !== exp_be(sz, a) || addr_s !== {a[31:2], 2'b00} || we_s !== rw ||
                    (rw && wd_s !== exp_wdata(sz, wd))) begin
                    failures++;
                    $display("FAIL rand_bus i=%0d be=%b/%b addr=%h/%h we=%b/%b wd=%h/%h", i, be_s, exp_be(sz, a),
                             addr_s, {a[31:2], 2'b00}, we_s, rw, wd_s, exp_wdata(sz, wd));
                end
            end
            if (el == 1) begin
                checks++;
                if (ld !== exp_load(sz, se, a, rd)) begin
                    failures++;
                    $display("FAIL rand_load i=%0d sz=%0d se=%b a=%h rd=%h got=%h exp=%h", i, sz, se, a, rd, ld,
                             exp_load(sz, se, a, rd));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int lv_seen;
        lv_seen = 0;
        bus.mem_enable = 1'b1; bus.mem_rw = 1'b0; bus.mem_size = SZ_WORD; bus.mem_se = 1'b0;
        bus.mem_addr = 32'h200; bus.dmem_rdata = 32'h1234_5678; bus.dmem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            if (bus.load_valid) lv_seen++;
            @(posedge clk); #1;
        end
        #2;
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.stall !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre req=%b stall=%b exp 1/1", bus.dmem_req, bus.stall);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL midreset_drop req=%b stall=%b exp 0/0", bus.dmem_req, bus.stall);
        end
        repeat (2) begin
            @(posedge clk); #4;
            if (bus.load_valid) lv_seen++;
        end
        @(posedge clk); #1;
        bus.mem_enable = 1'b0;
        reset = 1'b1;
        #4;
        if (bus.load_valid) lv_seen++;
        checks++;
        if (bus.stall !== 1'b0 || bus.dmem_req !== 1'b0 || lv_seen != 0) begin
            failures++;
            $display("FAIL midreset_after stall=%b req=%b lv_pulses=%0d exp 0/0/0", bus.stall, bus.dmem_req, lv_seen);
        end
        @(posedge clk); #1;
        run_access(1'b0, SZ_HALF, 1'b1, 32'h206, 32'h0, 32'h0000_8001, 0, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
        if (!done || n_stall != 2 || n_lv != 1 || ld !== 32'hFFFF_8001) begin
            failures++;
            $display("FAIL midreset_idle done=%0d stall=%0d lv=%0d ld=%h exp 1/2/1/FFFF8001", done, n_stall, n_lv, ld);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0, 32'hCAFE_F00D, 40, 1'b0,
                   n_stall, n_req, n_lv, n_mf, n_bf, ld, be_s, wd_s, addr_s, we_s, done);
        checks++;
`ifdef DMEM_CTRL_TIMEOUT_EN
        if (!done || n_req != 4 || n_stall != 5 || n_bf != 1 || n_lv != 0) begin
            failures++;
            $display("FAIL timeout done=%0d req=%0d stall=%0d bf=%0d lv=%0d exp 1/4/5/1/0",
                     done, n_req, n_stall, n_bf, n_lv);
        end
`else
        if (!done || n_req != 41 || n_stall != 42 || n_bf != 0 || n_lv != 1 || ld !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL no_timeout done=%0d req=%0d stall=%0d bf=%0d lv=%0d ld=%h exp 1/41/42/0/1/CAFEF00D",
                     done, n_req, n_stall, n_bf, n_lv, ld);
        end
`endif
    endtask

    initial begin
        bus.mem_enable = 1'b0; bus.mem_rw = 1'b0; bus.mem_size = '0; bus.mem_se = 1'b0;
        bus.mem_addr = '0; bus.mem_wdata = '0; bus.dmem_rdata = '0; bus.dmem_ack = 1'b0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misalign();
        test_back_to_back_random();
        test_reset_mid();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
